pic_irq_priority_resolver: RTL

Interrupt-detecting stage of the 8259A PIC, directly upstream of the control logic. It samples the eight IR pins into the Interrupt Request Register (IRR). It resolves the highest-priority unmasked request against the In-Service Register (ISR) under the rotating priority scheme, and drives the one-hot `interrupt` and `highest_level_in_service` vectors that the control logic consumes. It also applies the control logic's latch, clear, EOI, mask, rotate and freeze commands to the IRR and ISR.

---
 rtl/pic_irq_priority_resolver.sv | 97 +++++++++
 1 files changed

// File: rtl/pic_irq_priority_resolver.sv
// 8259A interrupt-detect stage: samples IR pins into the IRR and resolves the
// winning request against the ISR under rotating priority.
module pic_irq_priority_resolver #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] interrupt_request_pin,
   input  logic               level_or_edge_toriggered_config,
   input  logic               special_fully_nest_config,
   input  logic               freeze,
   input  logic               latch_in_service,
   input  logic [NUM_IRQ-1:0] clear_interrupt_request,
   input  logic [NUM_IRQ-1:0] interrupt_mask,
   input  logic [NUM_IRQ-1:0] interrupt_special_mask,
   input  logic [NUM_IRQ-1:0] end_of_interrupt,
   input  logic [2:0]         priority_rotate,
   output logic [NUM_IRQ-1:0] interrupt_request_register,
   output logic [NUM_IRQ-1:0] in_service_register,
   output logic [NUM_IRQ-1:0] interrupt,
   output logic [NUM_IRQ-1:0] highest_level_in_service
);

   logic [NUM_IRQ-1:0] prev_pin_q, prev_pin_d;
   logic [NUM_IRQ-1:0] irr_q, irr_d;
   logic [NUM_IRQ-1:0] isr_q, isr_d;
   logic [NUM_IRQ-1:0] interrupt_q, interrupt_d;

   logic [3:0]         rot_amt;
   logic [NUM_IRQ-1:0] cand_rot;
   logic [NUM_IRQ-1:0] block_rot;
   logic [NUM_IRQ-1:0] allowed_rot;
   logic [NUM_IRQ-1:0] winner;

   function automatic logic [NUM_IRQ-1:0] rot_r(input logic [NUM_IRQ-1:0] v,
                                                input logic [3:0] n);
      logic [2*NUM_IRQ-1:0] w;
      w = {v, v} >> n;
      return w[NUM_IRQ-1:0];
   endfunction

   function automatic logic [NUM_IRQ-1:0] rot_l(input logic [NUM_IRQ-1:0] v,
                                                input logic [3:0] n);
      logic [2*NUM_IRQ-1:0] w;
      w = {v, v} << n;
      return w[2*NUM_IRQ-1:NUM_IRQ];
   endfunction

   // Isolate the lowest set bit; in the rotated frame bit 0 is the highest priority.
   function automatic logic [NUM_IRQ-1:0] prio(input logic [NUM_IRQ-1:0] v);
      return v & (~v + NUM_IRQ'(1));
   endfunction

   always_comb begin
      rot_amt    = {1'b0, priority_rotate} + 4'd1;
      prev_pin_d = interrupt_request_pin;

      if (freeze)
         irr_d = irr_q;
      else if (level_or_edge_toriggered_config)
         irr_d = interrupt_request_pin;
      else
         irr_d = (irr_q | (~prev_pin_q & interrupt_request_pin)) & interrupt_request_pin;
      irr_d = irr_d & ~clear_interrupt_request;

      cand_rot  = rot_r(irr_q & ~interrupt_mask, rot_amt);
      block_rot = prio(rot_r(isr_q & ~interrupt_special_mask, rot_amt));
      // Bits strictly above the blocker; an empty blocker wraps to all ones.
      allowed_rot = (block_rot - NUM_IRQ'(1)) |
                    (special_fully_nest_config ? block_rot : '0);
      winner = rot_l(prio(cand_rot & allowed_rot), rot_amt);

      interrupt_d = freeze ? interrupt_q : winner;
      isr_d = (isr_q & ~end_of_interrupt) | (latch_in_service ? interrupt_q : '0);

      highest_level_in_service = rot_l(block_rot, rot_amt);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_pin_q  <= '0;
         irr_q       <= '0;
         isr_q       <= '0;
         interrupt_q <= '0;
      end else begin
         prev_pin_q  <= prev_pin_d;
         irr_q       <= irr_d;
         isr_q       <= isr_d;
         interrupt_q <= interrupt_d;
      end
   end

   assign interrupt_request_register = irr_q;
   assign in_service_register        = isr_q;
   assign interrupt                  = interrupt_q;

endmodule
